// File: rtl/axi2ahb_wr_fifo_pkg.sv
// Shared axi2ahb definitions: default bus widths, queue depths and BRESP codes
// used by the AXI-to-AHB write-data buffer.
package axi2ahb_wr_fifo_pkg;

  localparam int DATA_BITS_DEF  = 32;
  localparam int ID_BITS_DEF    = 4;
  localparam int FIFO_LINES_DEF = 32;
  localparam int CMD_DEPTH_DEF  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi2ahb_wr_fifo_prgen_fifo.sv
// Generic show-ahead FIFO: dout always presents the head entry; push while full
// and pop while empty are ignored.
module prgen_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH so non-power-of-two depths work too.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi2ahb_wr_fifo.sv
// AXI W-channel to AHB HWDATA buffer: stores write beats, tells the command side
// when a whole burst is ready, and turns AHB data-phase outcomes into B responses.
module axi2ahb_wr_fifo
  import axi2ahb_wr_fifo_pkg::*;
#(
  parameter int         DATA_BITS   = DATA_BITS_DEF,
  parameter int         ID_BITS     = ID_BITS_DEF,
  parameter int         FIFO_LINES  = FIFO_LINES_DEF,
  parameter int         CMD_DEPTH   = CMD_DEPTH_DEF,
  parameter logic [1:0] RESP_SLVERR = axi2ahb_wr_fifo_pkg::RESP_SLVERR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ID_BITS-1:0]   WID,
  input  logic [DATA_BITS-1:0] WDATA,
  input  logic                 WLAST,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [ID_BITS-1:0]   BID,
  output logic [1:0]           BRESP,
  output logic                 BVALID,
  input  logic                 BREADY,
  output logic [DATA_BITS-1:0] HWDATA,
  input  logic                 HREADY,
  input  logic                 HRESP,
  input  logic [ID_BITS-1:0]   cmd_id,
  input  logic                 cmd_err,
  input  logic                 wdata_phase,
  input  logic                 data_last,
  output logic                 wdata_ready,
  output logic                 wdata_underrun
);

  localparam int BW = $clog2(FIFO_LINES) + 1;

  logic [DATA_BITS:0]   data_dout;
  logic                 data_empty;
  logic                 data_full;
  logic                 data_push;
  logic                 data_pop;
  logic [ID_BITS+1:0]   resp_din;
  logic [ID_BITS+1:0]   resp_dout;
  logic                 resp_empty;
  logic                 resp_full;
  logic                 resp_push;
  logic                 resp_pop;
  logic                 beat_done;
  logic                 beat_err;
  logic                 cnt_inc;
  logic                 cnt_dec;
  logic [BW-1:0]        burst_cnt;
  logic                 burst_err;
  logic [ID_BITS-1:0]   unused_wid;

  assign unused_wid = WID;

  assign WREADY    = ~data_full;
  assign data_push = WVALID & WREADY;
  assign beat_done = wdata_phase & HREADY;
  assign data_pop  = beat_done & ~data_empty;
  assign beat_err  = HRESP | cmd_err;

  // Each stored line is {data, wlast}.
  prgen_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_LINES)
  ) u_data_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_push),
    .pop   (data_pop),
    .din   ({WDATA, WLAST}),
    .dout  (data_dout),
    .empty (data_empty),
    .full  (data_full)
  );

  assign HWDATA = data_empty ? '0 : data_dout[DATA_BITS:1];

  assign cnt_inc = data_push & WLAST;
  assign cnt_dec = data_pop & data_dout[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (cnt_inc & ~cnt_dec) begin
      burst_cnt <= burst_cnt + 1'b1;
    end else if (cnt_dec & ~cnt_inc) begin
      burst_cnt <= burst_cnt - 1'b1;
    end
  end

  // The error flag is consumed by the last beat's response and cleared with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_err <= 1'b0;
    end else if (beat_done & data_last) begin
      burst_err <= 1'b0;
    end else if (beat_done & beat_err) begin
      burst_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdata_underrun <= 1'b0;
    end else if (beat_done & data_empty) begin
      wdata_underrun <= 1'b1;
    end
  end

  assign resp_push = beat_done & data_last;
  assign resp_din  = {cmd_id, (burst_err | beat_err) ? RESP_SLVERR : RESP_OKAY};
  assign resp_pop  = BVALID & BREADY;

  prgen_fifo #(
    .WIDTH (ID_BITS + 2),
    .DEPTH (CMD_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (resp_push),
    .pop   (resp_pop),
    .din   (resp_din),
    .dout  (resp_dout),
    .empty (resp_empty),
    .full  (resp_full)
  );

  assign BVALID      = ~resp_empty;
  assign BID         = resp_empty ? '0 : resp_dout[ID_BITS+1:2];
  assign BRESP       = resp_empty ? 2'b00 : resp_dout[1:0];
  assign wdata_ready = (burst_cnt != '0) & ~resp_full;

endmodule

// File: tb/tb_axi2ahb_wr_fifo.sv
// Directed bench for axi2ahb_wr_fifo: bursts, error responses, full buffer,
// full response queue, concurrent push/pop of last beats, underrun and reset.
module tb_axi2ahb_wr_fifo;

  localparam int DATA_BITS = 32;
  localparam int ID_BITS   = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [ID_BITS-1:0]   WID;
  logic [DATA_BITS-1:0] WDATA;
  logic                 WLAST;
  logic                 WVALID;
  logic                 WREADY;
  logic [ID_BITS-1:0]   BID;
  logic [1:0]           BRESP;
  logic                 BVALID;
  logic                 BREADY;
  logic [DATA_BITS-1:0] HWDATA;
  logic                 HREADY;
  logic                 HRESP;
  logic [ID_BITS-1:0]   cmd_id;
  logic                 cmd_err;
  logic                 wdata_phase;
  logic                 data_last;
  logic                 wdata_ready;
  logic                 wdata_underrun;

  int n_chk = 0;
  int n_err = 0;
  int k;
  logic acc;

  axi2ahb_wr_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .WID            (WID),
    .WDATA          (WDATA),
    .WLAST          (WLAST),
    .WVALID         (WVALID),
    .WREADY         (WREADY),
    .BID            (BID),
    .BRESP          (BRESP),
    .BVALID         (BVALID),
    .BREADY         (BREADY),
    .HWDATA         (HWDATA),
    .HREADY         (HREADY),
    .HRESP          (HRESP),
    .cmd_id         (cmd_id),
    .cmd_err        (cmd_err),
    .wdata_phase    (wdata_phase),
    .data_last      (data_last),
    .wdata_ready    (wdata_ready),
    .wdata_underrun (wdata_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    WVALID = 1'b0;
    wdata_phase = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic w_beat(input logic [DATA_BITS-1:0] d, input logic last);
    WVALID = 1'b1;
    WDATA  = d;
    WLAST  = last;
    tick();
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  // One AHB data phase; HWDATA is checked before the completing edge.
  task automatic dphase(input string tag, input logic [ID_BITS-1:0] id, input logic last,
                        input logic hresp, input logic cerr, input logic [DATA_BITS-1:0] exp);
    wdata_phase = 1'b1;
    HREADY      = 1'b1;
    cmd_id      = id;
    data_last   = last;
    HRESP       = hresp;
    cmd_err     = cerr;
    chk(tag, HWDATA, exp);
    tick();
    wdata_phase = 1'b0;
    data_last   = 1'b0;
    HRESP       = 1'b0;
    cmd_err     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; WID = '0; WDATA = '0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b1; HREADY = 1'b0; HRESP = 1'b0; cmd_id = '0; cmd_err = 1'b0;
    wdata_phase = 1'b0; data_last = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_wready", WREADY, 1);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_bid", BID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_underrun", wdata_underrun, 0);

    // Clean 4-beat burst
    w_beat(32'hA0, 1'b0);
    chk("b1_show_ahead", HWDATA, 32'hA0);
    w_beat(32'hA1, 1'b0);
    w_beat(32'hA2, 1'b0);
    chk("b1_not_ready", wdata_ready, 0);
    w_beat(32'hA3, 1'b1);
    chk("b1_ready", wdata_ready, 1);
    for (int i = 0; i < 4; i++) dphase("b1_hwdata", 4'd3, i == 3, 1'b0, 1'b0, 32'hA0 + i);
    chk("b1_bvalid", BVALID, 1);
    chk("b1_bid", BID, 3);
    chk("b1_bresp", BRESP, 2'b00);
    chk("b1_ready_done", wdata_ready, 0);
    tick();
    chk("b1_bvalid_pop", BVALID, 0);

    // HRESP on beat 2, then a clean burst
    for (int i = 0; i < 4; i++) w_beat(32'hA0 + i, i == 3);
    for (int i = 0; i < 4; i++) dphase("b2_hwdata", 4'd3, i == 3, i == 1, 1'b0, 32'hA0 + i);
    chk("b2_bvalid", BVALID, 1);
    chk("b2_bresp_err", BRESP, 2'b10);
    tick();
    for (int i = 0; i < 4; i++) w_beat(32'hA0 + i, i == 3);
    for (int i = 0; i < 4; i++) dphase("b3_hwdata", 4'd3, i == 3, 1'b0, 1'b0, 32'hA0 + i);
    chk("b3_bresp_ok", BRESP, 2'b00);
    tick();

    // Fill the data buffer
    k = 0;
    for (int c = 0; c < 40; c++) begin
      WVALID = 1'b1; WDATA = 32'h100 + k; WLAST = (k % 4 == 3);
      acc = WREADY;
      tick();
      if (acc) k++;
    end
    chk("full_accepts", k, 32);
    chk("full_wready", WREADY, 0);
    chk("full_bursts_ready", wdata_ready, 1);
    WDATA = 32'h100 + k; WLAST = 1'b0;
    dphase("full_pop_hwdata", 4'd1, 1'b0, 1'b0, 1'b0, 32'h100);
    for (int c = 0; c < 5; c++) begin
      WVALID = 1'b1; WDATA = 32'h100 + k; WLAST = 1'b0;
      acc = WREADY;
      tick();
      if (acc) k++;
    end
    chk("full_one_more", k, 33);
    chk("full_wready_again", WREADY, 0);
    do_reset();
    tick();
    chk("rst2_wready", WREADY, 1);
    chk("rst2_hwdata", HWDATA, 0);
    chk("rst2_ready", wdata_ready, 0);

    // Response queue full blocks wdata_ready
    BREADY = 1'b0;
    for (int i = 0; i < 5; i++) w_beat(32'h50 + i, 1'b1);
    for (int i = 0; i < 4; i++) dphase("rq_hwdata", 4'(5 + i), 1'b1, 1'b0, 1'b0, 32'h50 + i);
    chk("rq_full_ready", wdata_ready, 0);
    chk("rq_bvalid", BVALID, 1);
    chk("rq_bid_first", BID, 5);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("rq_ready_after_b", wdata_ready, 1);
    chk("rq_bid_second", BID, 6);
    do_reset();
    BREADY = 1'b1;
    tick();

    // WLAST accepted while previous last beat pops
    w_beat(32'h60, 1'b0);
    w_beat(32'h61, 1'b1);
    dphase("cc_hwdata0", 4'd1, 1'b0, 1'b0, 1'b0, 32'h60);
    WVALID = 1'b1; WDATA = 32'h70; WLAST = 1'b1;
    dphase("cc_hwdata1", 4'd2, 1'b1, 1'b0, 1'b0, 32'h61);
    WVALID = 1'b0; WLAST = 1'b0;
    chk("cc_ready", wdata_ready, 1);
    chk("cc_hwdata_next", HWDATA, 32'h70);
    chk("cc_bvalid", BVALID, 1);
    chk("cc_bid", BID, 2);
    dphase("cc_hwdata2", 4'd4, 1'b1, 1'b0, 1'b0, 32'h70);
    chk("cc_bid2", BID, 4);
    chk("cc_ready_done", wdata_ready, 0);
    tick();

    // Underrun, then reset mid-burst
    dphase("ur_hwdata", 4'd7, 1'b1, 1'b0, 1'b1, 32'h0);
    chk("ur_flag", wdata_underrun, 1);
    chk("ur_bvalid", BVALID, 1);
    chk("ur_bid", BID, 7);
    chk("ur_bresp", BRESP, 2'b10);
    tick();
    w_beat(32'h80, 1'b0);
    w_beat(32'h81, 1'b1);
    chk("ur_sticky", wdata_underrun, 1);
    chk("ur_ready", wdata_ready, 1);
    BREADY = 1'b0;
    dphase("ur_hwdata2", 4'd9, 1'b1, 1'b0, 1'b0, 32'h80);
    chk("ur_pending", BVALID, 1);
    do_reset();
    chk("mr_bvalid", BVALID, 0);
    chk("mr_bid", BID, 0);
    chk("mr_ready", wdata_ready, 0);
    chk("mr_hwdata", HWDATA, 0);
    chk("mr_underrun", wdata_underrun, 0);
    chk("mr_wready", WREADY, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axi2ahb_wr_fifo.md
AXI2AHB_WR_FIFO -- requirements
Module: axi2ahb_wr_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32, meaning AXI W / AHB HWDATA width.
REQ-002 SHALL have parameter ID_BITS, default 4, meaning AXI ID width.
REQ-003 SHALL have parameter FIFO_LINES, default 32, meaning data buffer depth (double buffer of a 16-beat burst).
REQ-004 SHALL have parameter CMD_DEPTH, default 4, meaning response queue depth.
REQ-005 SHALL have parameter RESP_SLVERR, default 2'b10, meaning the error BRESP code.
REQ-006 Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- WID  in  ID_BITS  AXI write ID; not stored.
- WDATA  in  DATA_BITS  AXI write data.
- WLAST  in  1  last beat of AXI burst.
- WVALID  in  1  AXI write data valid.
- WREADY  out  1  AXI write data ready.
- BID  out  ID_BITS  response ID.
- BRESP  out  2  response code.
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- HWDATA  out  DATA_BITS  AHB write data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB error (1 = ERROR).
- cmd_id  in  ID_BITS  ID of the burst currently in AHB data phase.
- cmd_err  in  1  command already flagged as error.
- wdata_phase  in  1  AHB write data phase active.
- data_last  in  1  current data phase is the burst's last beat.
- wdata_ready  out  1  a full burst is buffered; the command side may start an AHB write burst.
- wdata_underrun  out  1  sticky: a data phase completed with the buffer empty.

Function
REQ-007 SHALL push {WDATA, WLAST} into the data buffer when WVALID & WREADY; WREADY = ~data_full.
REQ-008 SHALL pop the data buffer when wdata_phase & HREADY & ~data_empty.
REQ-009 SHALL drive HWDATA combinationally from the data buffer head (show-ahead); HWDATA = 0 when the buffer is empty.
REQ-010 A beat accepted on the W channel in cycle N SHALL be visible on HWDATA from cycle N+1 when the buffer was empty.
REQ-011 SHALL keep burst_cnt, width log2(FIFO_LINES)+1: +1 on an accepted WLAST beat, -1 on a popped beat whose stored WLAST = 1; simultaneous increment and decrement SHALL leave it unchanged.
REQ-012 wdata_ready SHALL be (burst_cnt > 0) & ~resp_full.
REQ-013 SHALL hold a sticky burst_err flag, set when wdata_phase & HREADY & (HRESP | cmd_err); cleared in the same cycle a last beat completes, after its value has been used.
REQ-014 On wdata_phase & HREADY & data_last, SHALL push {cmd_id, resp} into the response queue; resp = RESP_SLVERR if burst_err, HRESP or cmd_err is set in that beat, else 2'b00.
REQ-015 BVALID SHALL be ~resp_empty; {BID, BRESP} SHALL be the response queue head; pop on BVALID & BREADY; BVALID rises one cycle after the push.
REQ-016 Simultaneous push and pop on a full buffer SHALL be accepted for the pop only; push is blocked by WREADY/wdata_ready.
REQ-017 wdata_phase & HREADY with data_empty SHALL set wdata_underrun, leave the buffer and burst_cnt unchanged, and still push the response if data_last.
REQ-018 Data-buffer wrap-around SHALL be seamless; occupancy SHALL never exceed FIFO_LINES.

Reset
REQ-019 On reset, SHALL empty both queues and clear burst_cnt, burst_err and wdata_underrun.
REQ-020 On reset, outputs SHALL be WREADY=1 (from the following cycle), BVALID=0, BID=0, BRESP=0, HWDATA=0 and wdata_ready=0.
REQ-021 Reset asserted mid-burst SHALL discard all buffered data and pending responses without emitting them.

Structure
REQ-022 DATA_BITS, ID_BITS, CMD_DEPTH and response codes SHALL come from the shared axi2ahb definitions file.
REQ-023 SHALL instantiate the existing generic FIFO sub-module prgen_fifo twice: data width DATA_BITS+1, depth FIFO_LINES; and response width ID_BITS+2, depth CMD_DEPTH.
REQ-024 burst_cnt, the error flags and the handshake logic SHALL be local to this module.

Verification
REQ-025 Write 4-beat burst 0xA0..0xA3, WLAST on beat 4, BREADY=1 -> wdata_ready rises the cycle after beat 4; 4 HREADY data phases with cmd_id=3 -> HWDATA 0xA0..0xA3 in order; BVALID with BID=3, BRESP=00.
REQ-026 Same burst, HRESP=1 on beat 2 only -> BRESP=2'b10; the next clean burst -> BRESP=00.
REQ-027 Hold WVALID for 40 beats with no data phases -> WREADY=0 after 32 accepts; one pop -> exactly one further accept.
REQ-028 Complete 4 bursts with BREADY=0 -> resp_full, so wdata_ready=0 despite buffered bursts; one B handshake -> wdata_ready=1.
REQ-029 Accept WLAST while the last beat of the previous burst pops in the same cycle -> burst_cnt unchanged, no lost response.
REQ-030 Data phase with an empty buffer -> wdata_underrun=1 until reset; reset mid-burst -> BVALID=0, wdata_ready=0, buffer empty.
